uart_transmitter: RTL and testbench



---
 rtl/uart_transmitter.sv | 86 ++++++++
 tb/tb_uart_transmitter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter with valid/ready byte input; define UART_TX_PARITY_EN to add an even parity bit
module uart_transmitter #(
  parameter int clk_freq  = 100_000_000,
  parameter int baud_rate = 9_600,
  parameter int div_bit   = clk_freq / baud_rate
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] TxData,
  input  logic       TxValid,
  output logic       TxReady,
  output logic       TxD,
  output logic       TxDone
);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  localparam logic [15:0] last = 16'(div_bit - 1);
  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        bit_end;
  assign bit_end = cnt == last;
  assign TxReady = state == IDLE;
  // frame sequencer: the counter restarts at every bit boundary and stays cleared while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shreg  <= '0;
      TxD    <= 1'b1;
      TxDone <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      TxDone <= 1'b0;
      cnt    <= (state == IDLE || bit_end) ? 16'd0 : cnt + 16'd1;
      case (state)
        IDLE: if (TxValid) begin
          shreg <= TxData;
          state <= START;
          TxD   <= 1'b0;
`ifdef UART_TX_PARITY_EN
          par   <= ^TxData;
`endif
        end
        START: if (bit_end) begin
          state <= DATA;
          TxD   <= shreg[0];
          idx   <= 3'd0;
        end
        DATA: if (bit_end) begin
          shreg <= shreg >> 1;
          idx   <= idx + 3'd1;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state <= PARITY;
            TxD   <= par;
`else
            state <= STOP;
            TxD   <= 1'b1;
`endif
          end else
            TxD <= shreg[1];
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          state <= STOP;
          TxD   <= 1'b1;
        end
`endif
        STOP: if (bit_end) begin
          state  <= IDLE;
          TxDone <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench for uart_transmitter (div_bit 4 frame checks, div_bit 16 loopback receiver)
module tb_uart_transmitter;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int D = 4;
  typedef struct {logic [7:0] d; int gap; bit ab; int st;} ent_t;
  logic clk = 0, reset = 1;
  logic [7:0] TxData = 0, TxData1 = 0;
  logic TxValid = 0, TxValid1 = 0;
  logic TxReady, TxD, TxDone, TxReady1, TxD1, TxDone1;
  int total = 0, bad = 0, ncyc = 0, pos, bit_err, rdy_err, last_start = 0;
  bit active = 0, done_chk = 0, rst_seen = 0;
  ent_t sb[$], cur;
  logic [7:0] rx_q[$], rb;
  logic [10:0] fr;
  logic rstop, rpar;

  uart_transmitter #(.clk_freq(40), .baud_rate(10)) u0 (.clk(clk), .reset(reset), .TxData(TxData),
    .TxValid(TxValid), .TxReady(TxReady), .TxD(TxD), .TxDone(TxDone));
  uart_transmitter #(.clk_freq(160), .baud_rate(10)) u1 (.clk(clk), .reset(reset), .TxData(TxData1),
    .TxValid(TxValid1), .TxReady(TxReady1), .TxD(TxD1), .TxDone(TxDone1));

  always #5 clk = ~clk;

  function automatic logic [10:0] frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {2'b11, d, 1'b0};
`endif
  endfunction

  initial forever begin
    @(negedge clk);
    ncyc++;
    if (rst_seen) begin
      total++;
      if (TxD !== 1'b1 || TxReady !== 1'b1 || TxDone !== 1'b0) begin
        bad++;
        $display("FAIL reset_out: TxD=%b TxReady=%b TxDone=%b, want 1 1 0", TxD, TxReady, TxDone);
      end
      if (active) begin
        total++;
        if (sb.size() == 0 || !sb[0].ab) begin
          bad++;
          $display("FAIL abort: frame cut by reset, got queue size %0d, want an aborted entry", sb.size());
        end
        if (sb.size() != 0) void'(sb.pop_front());
        active = 0;
      end
      done_chk = 0;
    end else begin
      if (done_chk) begin
        total++;
        if (TxDone !== 1'b1 || TxReady !== 1'b1) begin
          bad++;
          $display("FAIL done: cycle %0d TxDone=%b TxReady=%b, want 1 1", ncyc, TxDone, TxReady);
        end
        done_chk = 0;
      end else if (TxDone === 1'b1) begin
        total++; bad++;
        $display("FAIL spurious_done: TxDone=1 at cycle %0d, want 0", ncyc);
      end
      if (!active && TxD === 1'b0) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_start: TxD=0 at cycle %0d with no byte queued", ncyc);
        end else begin
          cur = sb[0];
          total++;
          if (ncyc != cur.st) begin
            bad++;
            $display("FAIL start_time %h: start at %0d, want %0d", cur.d, ncyc, cur.st);
          end
          if (cur.gap != 0) begin
            total++;
            if (ncyc - last_start != cur.gap) begin
              bad++;
              $display("FAIL gap %h: start spacing %0d, want %0d", cur.d, ncyc - last_start, cur.gap);
            end
          end
          last_start = ncyc;
          fr = frame(cur.d);
          pos = 0; bit_err = 0; rdy_err = 0; active = 1;
        end
      end
      if (active) begin
        if (TxD !== fr[pos/D]) bit_err++;
        if (TxReady !== 1'b0) rdy_err++;
        pos++;
        if (pos == NB * D) begin
          total += 3;
          if (bit_err != 0) begin bad++; $display("FAIL bits %h: %0d wrong line cycles, want 0", cur.d, bit_err); end
          if (rdy_err != 0) begin bad++; $display("FAIL ready_low %h: %0d cycles TxReady!=0, want 0", cur.d, rdy_err); end
          if (cur.ab) begin bad++; $display("FAIL not_aborted %h: frame completed, want abandoned", cur.d); end
          void'(sb.pop_front());
          active = 0; done_chk = 1;
        end
      end
    end
    rst_seen = reset;
  end

  initial forever begin
    @(negedge clk);
    if (TxD1 === 1'b0 && reset === 1'b0) begin
      repeat (7) @(negedge clk);
      for (int i = 0; i < 8; i++) begin repeat (16) @(negedge clk); rb[i] = TxD1; end
`ifdef UART_TX_PARITY_EN
      repeat (16) @(negedge clk); rpar = TxD1;
`else
      rpar = ^rb;
`endif
      repeat (16) @(negedge clk); rstop = TxD1;
      total++;
      if (rx_q.size() == 0) begin
        bad++; $display("FAIL loopback: received %h with nothing expected", rb);
      end else begin
        if (rb !== rx_q[0] || rstop !== 1'b1 || rpar !== ^rx_q[0]) begin
          bad++; $display("FAIL loopback: RxData=%h stop=%b par=%b, want %h 1 %b", rb, rstop, rpar, rx_q[0], ^rx_q[0]);
        end
        void'(rx_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] d, input int gap, input bit ab, input bit hold);
    bit ok = 0;
    TxData = d; TxValid = 1;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk);
      if (TxReady === 1'b1 && reset === 1'b0) begin sb.push_back('{d, gap, ab, ncyc + 1}); ok = 1; end
    end
    #1;
    if (!hold) TxValid = 0;
    if (!ok) begin total++; bad++; $display("FAIL accept: %h not accepted within 500 cycles", d); end
  endtask

  task automatic send1(input logic [7:0] d);
    bit ok = 0;
    TxData1 = d; TxValid1 = 1;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk);
      if (TxReady1 === 1'b1) begin rx_q.push_back(d); ok = 1; end
    end
    #1;
    TxValid1 = 0;
    if (!ok) begin total++; bad++; $display("FAIL accept1: %h not accepted within 500 cycles", d); end
  endtask

  task automatic drain();
    for (int i = 0; i < 4000 && (sb.size() != 0 || done_chk || rx_q.size() != 0); i++) @(negedge clk);
    if (sb.size() != 0 || rx_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d frames and %0d loopback bytes outstanding, want 0", sb.size(), rx_q.size());
      sb.delete(); rx_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    TxValid = 1; TxData = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    send(8'h00, 0, 0, 0);
    drain();
    send(8'h55, 0, 0, 0);
    drain();
    send(8'hA5, 0, 0, 1);
    TxData = 8'hFF;
    repeat (10) @(posedge clk);
    #1;
    send(8'h3C, NB * D + 1, 0, 0);
    drain();
    send(8'h0F, 0, 1, 0);
    repeat (17) @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    send(8'h81, 0, 0, 0);
    drain();
    send(8'h07, 0, 0, 0);
    drain();
    send(8'h03, 0, 0, 0);
    drain();
    send1(8'hC3);
    drain();
    send1(8'h00);
    drain();
    send1(8'hFF);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
